// File: rtl/mp64_extmem_ctrl.sv
//==============================================================================
// Module      : mp64_extmem_ctrl
// Description : Bus-to-PHY external memory controller with read-data FIFO
//               and stalled-PHY timeout detection.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module mp64_extmem_ctrl #(
    parameter int FIFO_DEPTH  = 16,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_addr,
    input  logic        req_wen,
    input  logic [63:0] req_wdata,
    input  logic [3:0]  req_beats,
    output logic        rsp_valid,
    output logic [63:0] rsp_data,
    output logic        rsp_last,
    input  logic        rsp_ready,
    output logic        wr_done,
    output logic        err_timeout,
    input  logic        err_clr,
    output logic        phy_req,
    output logic [31:0] phy_addr,
    output logic        phy_wen,
    output logic [63:0] phy_wdata,
    output logic [3:0]  phy_burst_len,
    input  logic [63:0] phy_rdata,
    input  logic        phy_rvalid,
    input  logic        phy_ready
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int TW = $clog2(TIMEOUT_CYC + 1);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE   = 3'd1,
        S_SETTLE  = 3'd2,
        S_RD_WAIT = 3'd3,
        S_WR_WAIT = 3'd4
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;

    logic [63:0]   r_mem_data [FIFO_DEPTH];
    logic          r_mem_last [FIFO_DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [3:0]    r_beat_cnt;
    logic [TW-1:0] r_to_cnt;
    logic          r_err;
    logic [31:0]   r_phy_addr;
    logic          r_phy_wen;
    logic [63:0]   r_phy_wdata;
    logic [3:0]    r_phy_burst_len;

    logic [CW-1:0] w_free;
    logic [CW-1:0] w_need;
    logic          w_accept;
    logic          w_push;
    logic          w_push_last;
    logic          w_pop;
    logic          w_wr_ok;
    logic          w_waiting;
    logic          w_progress;
    logic          w_timeout;
    logic          w_unused_addr_lsb;

    assign w_unused_addr_lsb = ^req_addr[2:0];

    assign w_free    = CW'(FIFO_DEPTH) - r_count;
    assign w_need    = CW'(req_beats) + CW'(1);
    // Held low during reset so nothing is accepted while state is being cleared.
    assign req_ready = !sys_rst && (r_state == S_IDLE) && phy_ready &&
                       (req_wen || (w_free >= w_need));
    assign w_accept  = req_valid && req_ready;

    assign w_push      = (r_state == S_RD_WAIT) && phy_rvalid;
    assign w_push_last = w_push && (r_beat_cnt == r_phy_burst_len);
    assign w_wr_ok     = (r_state == S_WR_WAIT) && phy_ready;
    assign w_waiting   = (r_state == S_RD_WAIT) || (r_state == S_WR_WAIT);
    assign w_progress  = w_push || w_wr_ok;
    assign w_timeout   = w_waiting && !w_progress && (r_to_cnt == TW'(TIMEOUT_CYC - 1));

    assign rsp_valid = (r_count != '0);
    assign w_pop     = rsp_valid && rsp_ready;
    assign rsp_data  = rsp_valid ? r_mem_data[r_rd_ptr] : '0;
    assign rsp_last  = rsp_valid ? r_mem_last[r_rd_ptr] : 1'b0;

    assign err_timeout   = r_err;
    assign phy_addr      = r_phy_addr;
    assign phy_wen       = r_phy_wen;
    assign phy_wdata     = r_phy_wdata;
    assign phy_burst_len = r_phy_burst_len;

    always_comb begin
        w_state_nxt = r_state;
        phy_req     = 1'b0;
        wr_done     = 1'b0;
        case (r_state)
            S_IDLE:    if (w_accept) w_state_nxt = S_ISSUE;
            S_ISSUE: begin
                phy_req     = 1'b1;
                w_state_nxt = S_SETTLE;
            end
            // phy_ready still reflects the previous transaction here.
            S_SETTLE:  w_state_nxt = r_phy_wen ? S_WR_WAIT : S_RD_WAIT;
            S_RD_WAIT: if (w_push_last || w_timeout) w_state_nxt = S_IDLE;
            S_WR_WAIT: begin
                wr_done = w_wr_ok;
                if (w_wr_ok || w_timeout) w_state_nxt = S_IDLE;
            end
            default:   w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state         <= S_IDLE;
            r_wr_ptr        <= '0;
            r_rd_ptr        <= '0;
            r_count         <= '0;
            r_beat_cnt      <= '0;
            r_to_cnt        <= '0;
            r_err           <= 1'b0;
            r_phy_addr      <= '0;
            r_phy_wen       <= 1'b0;
            r_phy_wdata     <= '0;
            r_phy_burst_len <= '0;
        end else begin
            r_state <= w_state_nxt;

            if (w_accept) begin
                r_phy_addr      <= {req_addr[31:3], 3'b000};
                r_phy_wen       <= req_wen;
                r_phy_wdata     <= req_wdata;
                r_phy_burst_len <= req_wen ? 4'd0 : req_beats;
                r_beat_cnt      <= '0;
            end else if (w_push) begin
                r_beat_cnt <= r_beat_cnt + 4'd1;
            end

            if (!w_waiting || w_progress) r_to_cnt <= '0;
            else                          r_to_cnt <= r_to_cnt + 1'b1;

            if (w_timeout)    r_err <= 1'b1;
            else if (err_clr) r_err <= 1'b0;

            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge sys_clk) begin
        if (w_push) begin
            r_mem_data[r_wr_ptr] <= phy_rdata;
            r_mem_last[r_wr_ptr] <= w_push_last;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mp64_extmem_ctrl.sv
//==============================================================================
// Module      : tb_mp64_extmem_ctrl
// Description : Self-checking bench with a 1-cycle-latency PHY memory model.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mp64_extmem_ctrl;

    localparam int TO = 64;

    logic        sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    logic        sys_rst, req_valid, req_ready, req_wen, rsp_valid, rsp_last, rsp_ready;
    logic        wr_done, err_timeout, err_clr, phy_req, phy_wen, phy_ready, phy_rvalid;
    logic [31:0] req_addr, phy_addr;
    logic [63:0] req_wdata, rsp_data, phy_wdata, phy_rdata;
    logic [3:0]  req_beats, phy_burst_len;
    logic        m_rvalid, stray_rv, model_rst;

    assign phy_rvalid = m_rvalid | stray_rv;

    mp64_extmem_ctrl #(.FIFO_DEPTH(16), .TIMEOUT_CYC(TO)) dut (
        .sys_clk(sys_clk), .sys_rst(sys_rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
        .req_wen(req_wen), .req_wdata(req_wdata), .req_beats(req_beats),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_last(rsp_last),
        .rsp_ready(rsp_ready), .wr_done(wr_done), .err_timeout(err_timeout),
        .err_clr(err_clr), .phy_req(phy_req), .phy_addr(phy_addr),
        .phy_wen(phy_wen), .phy_wdata(phy_wdata), .phy_burst_len(phy_burst_len),
        .phy_rdata(phy_rdata), .phy_rvalid(phy_rvalid), .phy_ready(phy_ready)
    );

    // PHY model: ready drops one cycle after phy_req, one beat per cycle.
    logic [63:0] mem [1024];
    int          m_mode, m_cnt, m_len, stall_after;
    logic [9:0]  m_word;
    logic        m_wen;
    logic [63:0] m_wdata;

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 64'hA000_0000_0000_0000 | 64'(i);
        for (int i = 0; i < 9; i++) mem[10'h100 + 10'(i)] = 64'(i);
        m_mode = 0; m_cnt = 0; m_len = 0; m_word = '0; m_wen = 1'b0; m_wdata = '0;
        phy_ready = 1'b0; m_rvalid = 1'b0; phy_rdata = '0;
        forever begin
            @(negedge sys_clk);
            if (model_rst) begin
                m_mode = 0; phy_ready = 1'b1; m_rvalid = 1'b0;
            end else begin
                case (m_mode)
                    0: if (phy_req) begin
                        m_word = phy_addr[12:3]; m_wen = phy_wen; m_wdata = phy_wdata;
                        m_len = int'(phy_burst_len); m_cnt = 0; m_mode = 1;
                    end
                    1: begin phy_ready = 1'b0; m_mode = 2; end
                    2: if (m_wen) begin
                        mem[m_word] = m_wdata; phy_ready = 1'b1; m_mode = 0;
                    end else if (stall_after >= 0 && m_cnt == stall_after) begin
                        m_rvalid = 1'b0; m_mode = 3;
                    end else if (m_cnt > m_len) begin
                        m_rvalid = 1'b0; phy_ready = 1'b1; m_mode = 0;
                    end else begin
                        m_rvalid = 1'b1; phy_rdata = mem[m_word + 10'(m_cnt)]; m_cnt++;
                    end
                    default: m_rvalid = 1'b0;
                endcase
            end
        end
    end

    // Monitor: records popped beats, write completions and request strobes.
    logic [64:0] q [$];
    int          wr_cnt = 0, preq_cnt = 0;
    initial forever begin
        @(posedge sys_clk);
        if (rsp_valid && rsp_ready) q.push_back({rsp_last, rsp_data});
        if (wr_done) wr_cnt++;
        if (phy_req) preq_cnt++;
    end

    int n_err = 0, n_chk = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge sys_clk); #1;
    endtask

    task automatic do_req(input logic wen, input logic [31:0] addr, input logic [63:0] wd,
                          input logic [3:0] beats, output logic ok);
        req_wen = wen; req_addr = addr; req_wdata = wd; req_beats = beats;
        req_valid = 1'b1; ok = 1'b0;
        for (int n = 0; n < 200; n++) begin
            @(negedge sys_clk); #1;
            if (req_ready) begin ok = 1'b1; break; end
        end
        @(posedge sys_clk); #1;
        req_valid = 1'b0;
    endtask

    typedef struct {
        logic        wen;
        logic [31:0] addr;
        logic [63:0] wdata;
        logic [3:0]  beats;
        logic [31:0] exp_addr;
        logic [3:0]  exp_len;
    } vec_t;

    vec_t vecs[5];

    initial begin
        logic        ok, seen;
        int          qb, wb, pb, nrv;
        logic [64:0] e;
        logic [9:0]  w;

        vecs[0] = '{1'b1, 32'h0000_1008, 64'hDEAD_BEEF_0123_4567, 4'd0,  32'h0000_1008, 4'd0};
        vecs[1] = '{1'b0, 32'h0000_0805, 64'h0,                   4'd0,  32'h0000_0800, 4'd0};
        vecs[2] = '{1'b0, 32'h0000_0800, 64'h0,                   4'd7,  32'h0000_0800, 4'd7};
        vecs[3] = '{1'b1, 32'h0000_0FFF, 64'h0F0F_1234_5678_F0F0, 4'd5,  32'h0000_0FF8, 4'd0};
        vecs[4] = '{1'b0, 32'h0000_1238, 64'h0,                   4'd15, 32'h0000_1238, 4'd15};

        sys_rst = 1'b1; model_rst = 1'b1; req_valid = 1'b0; req_wen = 1'b0;
        req_addr = '0; req_wdata = '0; req_beats = '0; rsp_ready = 1'b0;
        err_clr = 1'b0; stray_rv = 1'b0; stall_after = -1;
        repeat (3) tick();
        @(negedge sys_clk); #1;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_phy_req", phy_req, 0);
        chk("rst_phy_addr", phy_addr, 0);
        chk("rst_err", err_timeout, 0);
        chk("rst_wr_done", wr_done, 0);
        tick();
        sys_rst = 1'b0; model_rst = 1'b0;
        tick();

        // Table-driven transactions with an always-ready bus side.
        rsp_ready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            qb = q.size(); wb = wr_cnt; pb = preq_cnt;
            do_req(vecs[i].wen, vecs[i].addr, vecs[i].wdata, vecs[i].beats, ok);
            chk($sformatf("v%0d_accept", i), ok, 1);
            chk($sformatf("v%0d_phy_req", i), phy_req, 1);
            chk($sformatf("v%0d_phy_addr", i), phy_addr, vecs[i].exp_addr);
            chk($sformatf("v%0d_phy_wen", i), phy_wen, vecs[i].wen);
            chk($sformatf("v%0d_burst_len", i), phy_burst_len, vecs[i].exp_len);
            if (vecs[i].wen) begin
                chk($sformatf("v%0d_phy_wdata", i), phy_wdata, vecs[i].wdata);
                for (int n = 0; n < 50 && wr_cnt == wb; n++) tick();
                repeat (3) tick();
                chk($sformatf("v%0d_wr_done_cnt", i), 64'(wr_cnt - wb), 1);
                w = vecs[i].exp_addr[12:3];
                chk($sformatf("v%0d_mem", i), mem[w], vecs[i].wdata);
            end else begin
                for (int n = 0; n < 200 && (q.size() - qb) < int'(vecs[i].beats) + 1; n++) tick();
                repeat (3) tick();
                chk($sformatf("v%0d_nbeats", i), 64'(q.size() - qb), 64'(vecs[i].beats) + 1);
                for (int k = 0; k <= int'(vecs[i].beats); k++) begin
                    e = q[qb + k];
                    w = vecs[i].exp_addr[12:3] + 10'(k);
                    chk($sformatf("v%0d_data%0d", i, k), e[63:0], mem[w]);
                    chk($sformatf("v%0d_last%0d", i, k), e[64], (k == int'(vecs[i].beats)) ? 1 : 0);
                end
            end
            chk($sformatf("v%0d_preq_cnt", i), 64'(preq_cnt - pb), 1);
        end

        // Backpressure: 8 beats held, a 9-beat request must wait for one pop.
        rsp_ready = 1'b0; qb = q.size();
        do_req(1'b0, 32'h0000_0800, 64'h0, 4'd7, ok);
        chk("bp_accept1", ok, 1);
        repeat (20) tick();
        chk("bp_no_pop", 64'(q.size() - qb), 0);
        chk("bp_rsp_valid", rsp_valid, 1);
        req_addr = 32'h0000_0800; req_beats = 4'd8; req_wen = 1'b0; req_valid = 1'b1;
        seen = 1'b0;
        for (int n = 0; n < 10; n++) begin
            @(negedge sys_clk); #1;
            if (req_ready) seen = 1'b1;
        end
        chk("bp_hold", seen, 0);
        tick(); rsp_ready = 1'b1;
        tick(); rsp_ready = 1'b0;
        @(negedge sys_clk); #1;
        chk("bp_release", req_ready, 1);
        tick(); req_valid = 1'b0;
        rsp_ready = 1'b1;
        for (int n = 0; n < 200 && (q.size() - qb) < 17; n++) tick();
        repeat (3) tick();
        chk("bp_nbeats", 64'(q.size() - qb), 17);
        for (int k = 0; k < 17; k++) begin
            e = q[qb + k];
            chk($sformatf("bp_data%0d", k), e[63:0], (k < 8) ? 64'(k) : 64'(k - 8));
            chk($sformatf("bp_last%0d", k), e[64], (k == 7 || k == 16) ? 1 : 0);
        end

        // Timeout: PHY returns 2 of 4 beats, then stalls.
        stall_after = 2; qb = q.size();
        do_req(1'b0, 32'h0000_0800, 64'h0, 4'd3, ok);
        chk("to_accept", ok, 1);
        nrv = 0; ok = 1'b0;
        for (int n = 0; n < 50; n++) begin
            @(negedge sys_clk); #1;
            if (phy_rvalid) begin
                nrv++;
                if (nrv == 2) begin ok = 1'b1; break; end
            end
        end
        chk("to_two_beats_seen", ok, 1);
        tick();
        repeat (TO - 1) tick();
        chk("to_not_yet", err_timeout, 0);
        tick();
        chk("to_rise", err_timeout, 1);
        chk("to_nbeats", 64'(q.size() - qb), 2);
        for (int k = 0; k < 2; k++) begin
            e = q[qb + k];
            chk($sformatf("to_data%0d", k), e[63:0], 64'(k));
            chk($sformatf("to_last%0d", k), e[64], 0);
        end
        repeat (2) tick();
        chk("to_sticky", err_timeout, 1);
        err_clr = 1'b1; tick(); err_clr = 1'b0;
        chk("to_clr", err_timeout, 0);
        model_rst = 1'b1; stall_after = -1; tick(); model_rst = 1'b0; tick();

        // Reset during RD_WAIT, then a stray beat while idle.
        rsp_ready = 1'b0;
        do_req(1'b0, 32'h0000_0800, 64'h0, 4'd15, ok);
        chk("rstrd_accept", ok, 1);
        repeat (6) tick();
        chk("rstrd_pre_valid", rsp_valid, 1);
        sys_rst = 1'b1; model_rst = 1'b1;
        tick();
        chk("rstrd_rsp_valid", rsp_valid, 0);
        chk("rstrd_rsp_data", rsp_data, 0);
        chk("rstrd_rsp_last", rsp_last, 0);
        chk("rstrd_req_ready", req_ready, 0);
        chk("rstrd_phy_req", phy_req, 0);
        chk("rstrd_phy_addr", phy_addr, 0);
        chk("rstrd_phy_len", phy_burst_len, 0);
        chk("rstrd_phy_wen", phy_wen, 0);
        chk("rstrd_wr_done", wr_done, 0);
        chk("rstrd_err", err_timeout, 0);
        sys_rst = 1'b0; model_rst = 1'b0; rsp_ready = 1'b1;
        tick();
        stray_rv = 1'b1; tick(); stray_rv = 1'b0;
        seen = 1'b0;
        for (int n = 0; n < 4; n++) begin
            @(negedge sys_clk); #1;
            if (rsp_valid) seen = 1'b1;
        end
        chk("stray_dropped", seen, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
